// File: rtl/beta_pkg.sv
// ---------------------------------------------------------------------------
// beta_pkg
// Shared types for the data-memory responder.
//   resp_state_t : responder sequencing (idle / latency wait / response cycle)
//   resp_kind_t  : transaction kind, also used as the round-robin preference
// ---------------------------------------------------------------------------
package beta_pkg;

    typedef enum logic [1:0] {
        RESP_IDLE = 2'd0,
        RESP_WAIT = 2'd1,
        RESP_DONE = 2'd2
    } resp_state_t;

    typedef enum logic {
        KIND_READ  = 1'b0,
        KIND_WRITE = 1'b1
    } resp_kind_t;

endpackage

// File: rtl/beta_sram_bytewr.sv
// ---------------------------------------------------------------------------
// beta_sram_bytewr
// Single-port word array with per-byte write enables and asynchronous read.
// Contents are deliberately not reset.
// Ports:
//   clk   in  clock
//   addr  in  word index (shared by read and write)
//   we    in  write enable for this cycle
//   be    in  byte enables, byte i written iff be[i]
//   wdata in  write word
//   rdata out word currently stored at addr
// ---------------------------------------------------------------------------
module beta_sram_bytewr #(
    parameter int DataWidth  = 32,
    parameter int DepthWords = 1024,
    localparam int AddrBits  = $clog2(DepthWords),
    localparam int StrbW     = DataWidth / 8
) (
    input  logic                 clk,
    input  logic [AddrBits-1:0]  addr,
    input  logic                 we,
    input  logic [StrbW-1:0]     be,
    input  logic [DataWidth-1:0] wdata,
    output logic [DataWidth-1:0] rdata
);

    logic [DataWidth-1:0] mem [DepthWords];

    // Byte-masked write port.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < StrbW; i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/beta_dmem_responder.sv
// ---------------------------------------------------------------------------
// beta_dmem_responder
// Memory-side responder for a split read/write data port. One transaction is
// in flight at a time; accept-to-valid distance is Latency cycles, followed by
// a return to idle, so back-to-back throughput is one per Latency+1 cycles.
// Ports:
//   clk_i, rstn_i                clock, synchronous active-low reset
//   rdata_req/addr/strb_i        read request channel (strb informational)
//   rdata_ready_o                read accepted this cycle (combinational)
//   rdata_valid_o, rdata_data_o  read response pulse and held read word
//   wdata_req/addr/data/strb_i   write request channel
//   wdata_ready_o                write accepted this cycle (combinational)
//   wdata_valid_o                write committed pulse
//   err_o                        pulses with valid for out-of-range index
// ---------------------------------------------------------------------------
module beta_dmem_responder
    import beta_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int DepthWords   = 1024,
    parameter int Latency      = 1
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      rdata_req_i,
    input  logic [AddressWidth-1:0]   rdata_addr_i,
    input  logic [DataWidth/8-1:0]    rdata_strb_i,
    output logic                      rdata_ready_o,
    output logic                      rdata_valid_o,
    output logic [DataWidth-1:0]      rdata_data_o,
    input  logic                      wdata_req_i,
    input  logic [AddressWidth-1:0]   wdata_addr_i,
    input  logic [DataWidth-1:0]      wdata_data_i,
    input  logic [DataWidth/8-1:0]    wdata_strb_i,
    output logic                      wdata_ready_o,
    output logic                      wdata_valid_o,
    output logic                      err_o
);

    localparam int StrbW     = DataWidth / 8;
    localparam int OffBits   = $clog2(StrbW);
    localparam int IdxW      = AddressWidth - OffBits;
    localparam int DepthBits = $clog2(DepthWords);
    // The counter only ever holds Latency-1 down to 1.
    localparam int CntW      = (Latency > 1) ? $clog2(Latency) : 1;
    localparam bit SingleCyc = (Latency == 1);

    resp_state_t          state_r;
    logic [CntW-1:0]      cnt_r;
    resp_kind_t           rr_prio_r;
    resp_kind_t           kind_r;
    logic [IdxW-1:0]      idx_r;
    logic [DataWidth-1:0] data_r;
    logic [StrbW-1:0]     strb_r;
    logic                 rvalid_r;
    logic                 wvalid_r;
    logic                 err_r;
    logic [DataWidth-1:0] rdata_r;

    logic                 grant_read_s;
    logic                 grant_write_s;
    logic                 accept_s;
    resp_kind_t           cur_kind_s;
    logic [IdxW-1:0]      cur_idx_s;
    logic [DataWidth-1:0] cur_data_s;
    logic [StrbW-1:0]     cur_strb_s;
    logic                 in_range_s;
    logic                 enter_resp_s;
    logic                 mem_we_s;
    logic [DataWidth-1:0] mem_rdata_s;
    logic                 unused_bits_s;

    // Byte offset bits never select anything: misaligned addresses alias the word.
    assign unused_bits_s = ^{rdata_addr_i[OffBits-1:0], wdata_addr_i[OffBits-1:0]};

    // Arbitration: only in idle and out of reset; contention goes to rr_prio_r.
    always_comb begin
        grant_read_s  = 1'b0;
        grant_write_s = 1'b0;
        if (rstn_i && (state_r == RESP_IDLE)) begin
            if (rdata_req_i && wdata_req_i) begin
                if (rr_prio_r == KIND_READ) begin
                    grant_read_s = 1'b1;
                end else begin
                    grant_write_s = 1'b1;
                end
            end else begin
                grant_read_s  = rdata_req_i;
                grant_write_s = wdata_req_i;
            end
        end else begin
            grant_read_s  = 1'b0;
            grant_write_s = 1'b0;
        end
    end

    assign accept_s      = grant_read_s | grant_write_s;
    assign rdata_ready_o = grant_read_s;
    assign wdata_ready_o = grant_write_s;

    // Current transaction: the incoming request while idle (needed when
    // Latency is 1), otherwise the captured one.
    always_comb begin
        cur_kind_s = kind_r;
        cur_idx_s  = idx_r;
        cur_data_s = data_r;
        cur_strb_s = strb_r;
        if (state_r == RESP_IDLE) begin
            if (grant_write_s) begin
                cur_kind_s = KIND_WRITE;
                cur_idx_s  = wdata_addr_i[AddressWidth-1:OffBits];
                cur_strb_s = wdata_strb_i;
            end else begin
                cur_kind_s = KIND_READ;
                cur_idx_s  = rdata_addr_i[AddressWidth-1:OffBits];
                cur_strb_s = rdata_strb_i;
            end
            cur_data_s = wdata_data_i;
        end else begin
            cur_kind_s = kind_r;
            cur_idx_s  = idx_r;
            cur_data_s = data_r;
            cur_strb_s = strb_r;
        end
    end

    assign in_range_s = (cur_idx_s < IdxW'(DepthWords));

    // The edge that moves into the response cycle is where the array is
    // read and written, so the pulse and the committed state appear together.
    always_comb begin
        enter_resp_s = 1'b0;
        if (!rstn_i) begin
            enter_resp_s = 1'b0;
        end else if (state_r == RESP_IDLE) begin
            enter_resp_s = accept_s && SingleCyc;
        end else if (state_r == RESP_WAIT) begin
            enter_resp_s = (cnt_r == CntW'(1));
        end else begin
            enter_resp_s = 1'b0;
        end
    end

    assign mem_we_s = enter_resp_s && (cur_kind_s == KIND_WRITE) && in_range_s;

    beta_sram_bytewr #(
        .DataWidth  (DataWidth),
        .DepthWords (DepthWords)
    ) u_sram (
        .clk   (clk_i),
        .addr  (cur_idx_s[DepthBits-1:0]),
        .we    (mem_we_s),
        .be    (cur_strb_s),
        .wdata (cur_data_s),
        .rdata (mem_rdata_s)
    );

    // Sequencing FSM with capture registers and registered response outputs.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r   <= RESP_IDLE;
            cnt_r     <= '0;
            rr_prio_r <= KIND_READ;
            kind_r    <= KIND_READ;
            idx_r     <= '0;
            data_r    <= '0;
            strb_r    <= '0;
            rvalid_r  <= 1'b0;
            wvalid_r  <= 1'b0;
            err_r     <= 1'b0;
            rdata_r   <= '0;
        end else begin
            rvalid_r <= enter_resp_s && (cur_kind_s == KIND_READ);
            wvalid_r <= enter_resp_s && (cur_kind_s == KIND_WRITE);
            err_r    <= enter_resp_s && !in_range_s;
            if (enter_resp_s && (cur_kind_s == KIND_READ)) begin
                rdata_r <= in_range_s ? mem_rdata_s : '0;
            end else begin
                rdata_r <= rdata_r;
            end

            case (state_r)
                RESP_IDLE: begin
                    if (accept_s) begin
                        // Prefer the other port next time there is contention.
                        rr_prio_r <= grant_write_s ? KIND_READ : KIND_WRITE;
                        kind_r    <= cur_kind_s;
                        idx_r     <= cur_idx_s;
                        data_r    <= cur_data_s;
                        strb_r    <= cur_strb_s;
                        if (SingleCyc) begin
                            state_r <= RESP_DONE;
                        end else begin
                            state_r <= RESP_WAIT;
                            cnt_r   <= CntW'(Latency - 1);
                        end
                    end else begin
                        state_r <= RESP_IDLE;
                    end
                end
                RESP_WAIT: begin
                    if (cnt_r == CntW'(1)) begin
                        state_r <= RESP_DONE;
                    end else begin
                        cnt_r <= cnt_r - CntW'(1);
                    end
                end
                RESP_DONE: begin
                    state_r <= RESP_IDLE;
                end
                default: begin
                    state_r <= RESP_IDLE;
                end
            endcase
        end
    end

    assign rdata_valid_o = rvalid_r;
    assign wdata_valid_o = wvalid_r;
    assign err_o         = err_r;
    assign rdata_data_o  = rdata_r;

endmodule

// File: tb/tb_beta_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_beta_dmem_responder
// Two responders (Latency 1 and Latency 3) driven by directed sequences and
// randomized request streams. A transaction-level reference model (due cycle,
// byte-masked word memory with per-byte known flags, round-robin preference)
// predicts every output on every cycle; directed cases add literal checks.
// ---------------------------------------------------------------------------
module tb_beta_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn  [2];
    logic        rreq  [2];
    logic [31:0] raddr [2];
    logic [3:0]  rstrb [2];
    logic        rrdy  [2];
    logic        rval  [2];
    logic [31:0] rdat  [2];
    logic        wreq  [2];
    logic [31:0] waddr [2];
    logic [31:0] wdat  [2];
    logic [3:0]  wstrb [2];
    logic        wrdy  [2];
    logic        wval  [2];
    logic        err   [2];

    beta_dmem_responder #(.Latency(1)) u_l1 (
        .clk_i(clk), .rstn_i(rstn[0]),
        .rdata_req_i(rreq[0]), .rdata_addr_i(raddr[0]), .rdata_strb_i(rstrb[0]),
        .rdata_ready_o(rrdy[0]), .rdata_valid_o(rval[0]), .rdata_data_o(rdat[0]),
        .wdata_req_i(wreq[0]), .wdata_addr_i(waddr[0]), .wdata_data_i(wdat[0]),
        .wdata_strb_i(wstrb[0]), .wdata_ready_o(wrdy[0]), .wdata_valid_o(wval[0]),
        .err_o(err[0])
    );

    beta_dmem_responder #(.Latency(3)) u_l3 (
        .clk_i(clk), .rstn_i(rstn[1]),
        .rdata_req_i(rreq[1]), .rdata_addr_i(raddr[1]), .rdata_strb_i(rstrb[1]),
        .rdata_ready_o(rrdy[1]), .rdata_valid_o(rval[1]), .rdata_data_o(rdat[1]),
        .wdata_req_i(wreq[1]), .wdata_addr_i(waddr[1]), .wdata_data_i(wdat[1]),
        .wdata_strb_i(wstrb[1]), .wdata_ready_o(wrdy[1]), .wdata_valid_o(wval[1]),
        .err_o(err[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, per instance.
    bit          m_pend  [2];
    bit          m_wr    [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_data  [2];
    logic [3:0]  m_strb  [2];
    int          m_due   [2];
    bit          m_rr    [2];   // 0: read preferred on contention, 1: write
    logic [31:0] m_held  [2];
    logic [31:0] m_hmask [2];
    logic [31:0] m_mem   [2][1024];
    logic [3:0]  m_known [2][1024];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp, input logic [31:0] mask);
        n_cmp++;
        if (((act ^ exp) & mask) != 32'h0) begin
            n_bad++;
            $display("FAIL %s inst%0d cyc%0d: actual %h expected %h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string nm, input int k);
        n_cmp++;
        n_bad++;
        $display("FAIL %s inst%0d cyc%0d: actual timeout expected event", nm, k, cyc);
    endtask

    // One cycle of the model for instance k: predict, compare, then advance.
    task automatic model_step(input int k);
        bit          busy;
        bit          fire;
        bit          oor;
        bit          gr;
        bit          gw;
        logic [31:0] word;
        busy = m_pend[k];
        fire = m_pend[k] && (cyc == m_due[k]);
        word = m_addr[k] >> 2;
        oor  = (word >= 32'd1024);
        if (fire) begin
            if (!m_wr[k]) begin
                if (oor) begin
                    m_held[k]  = 32'h0;
                    m_hmask[k] = 32'hFFFF_FFFF;
                end else begin
                    m_held[k] = m_mem[k][word];
                    for (int b = 0; b < 4; b++)
                        m_hmask[k][b*8 +: 8] = m_known[k][word][b] ? 8'hFF : 8'h00;
                end
            end else if (!oor) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_strb[k][b]) begin
                        m_mem[k][word][b*8 +: 8] = m_data[k][b*8 +: 8];
                        m_known[k][word][b] = 1'b1;
                    end
                end
            end
            m_pend[k] = 1'b0;
        end
        gr = rstn[k] && !busy && rreq[k] && (!wreq[k] || !m_rr[k]);
        gw = rstn[k] && !busy && wreq[k] && (!rreq[k] || m_rr[k]);
        chk("rdata_ready", k, 32'(rrdy[k]), 32'(gr), 32'h1);
        chk("wdata_ready", k, 32'(wrdy[k]), 32'(gw), 32'h1);
        chk("rdata_valid", k, 32'(rval[k]), 32'(fire && !m_wr[k]), 32'h1);
        chk("wdata_valid", k, 32'(wval[k]), 32'(fire && m_wr[k]), 32'h1);
        chk("err", k, 32'(err[k]), 32'(fire && oor), 32'h1);
        chk("rdata_data", k, rdat[k], m_held[k], m_hmask[k]);
        if (!rstn[k]) begin
            m_pend[k]  = 1'b0;
            m_rr[k]    = 1'b0;
            m_held[k]  = 32'h0;
            m_hmask[k] = 32'hFFFF_FFFF;
        end else if (gr || gw) begin
            m_pend[k] = 1'b1;
            m_wr[k]   = gw;
            m_addr[k] = gw ? waddr[k] : raddr[k];
            m_data[k] = wdat[k];
            m_strb[k] = wstrb[k];
            m_due[k]  = cyc + lat_of(k);
            m_rr[k]   = gr;
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        for (int k = 0; k < 2; k++) begin
            m_pend[k]  = 1'b0;
            m_rr[k]    = 1'b0;
            m_held[k]  = 32'h0;
            m_hmask[k] = 32'hFFFF_FFFF;
            for (int w = 0; w < 1024; w++) m_known[k][w] = 4'h0;
        end
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                model_step(0);
                model_step(1);
            end
        end
    end

    // Single directed transaction: returns read word, err and accept-to-valid.
    task automatic txn(input int k, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic er, output int lat);
        bit ok;
        int acc;
        rd  = 32'h0;
        er  = 1'b0;
        lat = -1;
        @(posedge clk); #1;
        if (wr) begin
            waddr[k] = a; wdat[k] = d; wstrb[k] = s; wreq[k] = 1'b1;
        end else begin
            raddr[k] = a; rstrb[k] = s; rreq[k] = 1'b1;
        end
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (wr ? wrdy[k] : rrdy[k]) ok = 1'b1;
        end
        acc = cyc;
        @(posedge clk); #1;
        wreq[k] = 1'b0;
        rreq[k] = 1'b0;
        if (!ok) begin
            timeout("txn_accept", k);
            return;
        end
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (wr ? wval[k] : rval[k]) begin
                ok  = 1'b1;
                rd  = rdat[k];
                er  = err[k];
                lat = cyc - acc;
            end
        end
        if (!ok) timeout("txn_valid", k);
    endtask

    // Random request stream on one port; occasionally withdraws before accept.
    task automatic rand_port(input int k, input bit wr, input int n);
        logic [31:0] word;
        logic [31:0] a;
        bit          done;
        bit          hit;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1;
            word = ($urandom_range(0, 7) == 0) ? 32'(1024 + $urandom_range(0, 15))
                                               : 32'($urandom_range(0, 15));
            a = (word << 2) | 32'($urandom_range(0, 3));
            if (wr) begin
                waddr[k] = a; wdat[k] = $urandom; wstrb[k] = 4'($urandom); wreq[k] = 1'b1;
            end else begin
                raddr[k] = a; rstrb[k] = 4'($urandom); rreq[k] = 1'b1;
            end
            done = 1'b0;
            hit  = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                @(negedge clk);
                if (wr ? wrdy[k] : rrdy[k]) begin
                    done = 1'b1;
                    hit  = 1'b1;
                end else if ($urandom_range(0, 7) == 0) begin
                    done = 1'b1;
                end
            end
            if (!done) timeout("rand_accept", k);
            if (hit) m_known[k][0][0] = m_known[k][0][0]; // accepted; model tracks it
            @(posedge clk); #1;
            if (wr) wreq[k] = 1'b0;
            else    rreq[k] = 1'b0;
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    bit          g [4];
    int          ng;
    bit          ok;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rstn[k] = 1'b0; rreq[k] = 1'b0; wreq[k] = 1'b0;
            raddr[k] = 32'h0; rstrb[k] = 4'h0;
            waddr[k] = 32'h0; wdat[k] = 32'h0; wstrb[k] = 4'h0;
        end
        // Reset with both requests held: nothing may be accepted or pulsed.
        rreq[0] = 1'b1; raddr[0] = 32'h0000_0024; rstrb[0] = 4'hF;
        wreq[0] = 1'b1; waddr[0] = 32'h0000_0020; wdat[0] = 32'h0BAD_F00D; wstrb[0] = 4'hF;
        repeat (2) begin
            @(negedge clk);
            chk("rst_rready", 0, 32'(rrdy[0]), 32'h0, 32'h1);
            chk("rst_wready", 0, 32'(wrdy[0]), 32'h0, 32'h1);
            chk("rst_valid",  0, 32'(rval[0] | wval[0] | err[0]), 32'h0, 32'h1);
            chk("rst_valid",  1, 32'(rval[1] | wval[1] | err[1]), 32'h0, 32'h1);
        end
        @(posedge clk); #1;
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;

        // Contention: grants must go R,W,R,W, never both in one cycle.
        ng = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("one_ready", 0, 32'(rrdy[0] & wrdy[0]), 32'h0, 32'h1);
            if ((rrdy[0] || wrdy[0]) && ng < 4) begin
                g[ng] = wrdy[0];
                ng++;
            end
        end
        chk("grant_count", 0, 32'(ng), 32'd4, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) chk("grant_order", 0, 32'(g[i]), 32'(i % 2), 32'h1);
        @(posedge clk); #1;
        rreq[0] = 1'b0;
        wreq[0] = 1'b0;

        // Full write then read back, Latency 1.
        txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        chk("t2_wr_err", 0, 32'(er), 32'h0, 32'h1);
        chk("t2_wr_lat", 0, 32'(lat), 32'd1, 32'hFFFF_FFFF);
        txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, rd, er, lat);
        chk("t2_rd_data", 0, rd, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        chk("t2_rd_lat", 0, 32'(lat), 32'd1, 32'hFFFF_FFFF);

        // Byte-0 partial write, then aligned and misaligned reads.
        txn(0, 1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, rd, er, lat);
        txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, rd, er, lat);
        chk("t3_rd_10", 0, rd, 32'hDEAD_BEAA, 32'hFFFF_FFFF);
        txn(0, 1'b0, 32'h0000_0013, 32'h0, 4'h1, rd, er, lat);
        chk("t3_rd_13", 0, rd, 32'hDEAD_BEAA, 32'hFFFF_FFFF);

        // Latency 3 and out-of-range accesses (0x4000 is word 4096).
        txn(1, 1'b1, 32'h0000_0000, 32'h5566_7788, 4'hF, rd, er, lat);
        txn(1, 1'b0, 32'h0000_4000, 32'h0, 4'hF, rd, er, lat);
        chk("t5_oor_data", 1, rd, 32'h0, 32'hFFFF_FFFF);
        chk("t5_oor_err", 1, 32'(er), 32'h1, 32'h1);
        chk("t5_oor_lat", 1, 32'(lat), 32'd3, 32'hFFFF_FFFF);
        txn(1, 1'b1, 32'h0000_4000, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        chk("t5_oorw_err", 1, 32'(er), 32'h1, 32'h1);
        txn(1, 1'b0, 32'h0000_0000, 32'h0, 4'hF, rd, er, lat);
        chk("t5_alias_data", 1, rd, 32'h5566_7788, 32'hFFFF_FFFF);
        chk("t5_alias_err", 1, 32'(er), 32'h0, 32'h1);

        // Reset while a write waits: it must never commit.
        txn(1, 1'b1, 32'h0000_0010, 32'h1122_3344, 4'hF, rd, er, lat);
        @(posedge clk); #1;
        waddr[1] = 32'h0000_0010; wdat[1] = 32'hCAFE_F00D; wstrb[1] = 4'hF; wreq[1] = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (wrdy[1]) ok = 1'b1;
        end
        if (!ok) timeout("t6_accept", 1);
        @(posedge clk); #1;
        wreq[1] = 1'b0;
        @(posedge clk); #1;
        rstn[1] = 1'b0;
        @(posedge clk); #1;
        rstn[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t6_no_wvalid", 1, 32'(wval[1]), 32'h0, 32'h1);
        end
        txn(1, 1'b0, 32'h0000_0010, 32'h0, 4'hF, rd, er, lat);
        chk("t6_old_data", 1, rd, 32'h1122_3344, 32'hFFFF_FFFF);

        // Randomized streams on all four ports.
        fork
            rand_port(0, 1'b0, 40);
            rand_port(0, 1'b1, 40);
            rand_port(1, 1'b0, 40);
            rand_port(1, 1'b1, 40);
        join
        repeat (6) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
